// File: rtl/secmem_reader_if.sv
// Address/value port toward the secure memory plus the captured-byte stream.
// The master side is the reader; the slave side is the memory and stream consumer.
interface secmem_reader_if #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8
);
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic [ADDR_BITS-1:0] out_addr;

  modport master (
    output mem_addr,
    input  mem_value,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr
  );

  modport slave (
    input  mem_addr,
    output mem_value,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr
  );
endinterface

// File: rtl/secmem_reader.sv
// Sweeps addresses 0..LAST_ADDR of a slow, asynchronous secure memory and streams
// each byte once it has been stable for STABLE_COUNT synchronised samples.
module secmem_reader #(
  parameter int ADDR_BITS     = 5,
  parameter int DATA_BITS     = 8,
  parameter int LAST_ADDR     = 31,
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_COUNT  = 4,
  parameter int TIMEOUT       = 10_400_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic timed_out,
  secmem_reader_if.master bus
);

  localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int STB_W = $clog2(STABLE_COUNT) + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  localparam logic [SET_W-1:0]     SETTLE_END = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [STB_W-1:0]     STABLE_END = STB_W'(STABLE_COUNT);
  localparam logic [TMO_W-1:0]     TMO_END    = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_BITS-1:0] LAST       = ADDR_BITS'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_EMIT,
    S_FIN
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] cur;
  logic [SET_W-1:0]     settle_cnt;
  logic [STB_W-1:0]     stable_cnt;
  logic [STB_W-1:0]     stable_nxt;
  logic [TMO_W-1:0]     wait_cnt;
  logic [DATA_BITS-1:0] sv_p0;
  logic [DATA_BITS-1:0] sv_p1;
  logic [DATA_BITS-1:0] prev_sv;

  // Stage p0/p1: two-flop synchroniser for the memory's unrelated clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sv_p0 <= '0;
      sv_p1 <= '0;
    end else begin
      sv_p0 <= bus.mem_value;
      sv_p1 <= sv_p0;
    end
  end

  // A zero stable count marks the first sample after SETTLE: prev_sv is stale then.
  assign stable_nxt = (stable_cnt != '0 && sv_p1 == prev_sv) ? stable_cnt + 1'b1
                                                              : STB_W'(1);

  assign bus.mem_addr = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cur           <= '0;
      settle_cnt    <= '0;
      stable_cnt    <= '0;
      wait_cnt      <= '0;
      prev_sv       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timed_out     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            timed_out  <= 1'b0;
            cur        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_END) begin
            settle_cnt <= '0;
            stable_cnt <= '0;
            wait_cnt   <= '0;
            state      <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          prev_sv    <= sv_p1;
          stable_cnt <= stable_nxt;
          wait_cnt   <= wait_cnt + 1'b1;
          if (stable_nxt == STABLE_END) begin
            bus.out_data  <= sv_p1;
            bus.out_addr  <= cur;
            bus.out_valid <= 1'b1;
            state         <= S_EMIT;
          end else if (wait_cnt == TMO_END) begin
            // Give up waiting: emit whatever is on the bus and flag the sweep.
            bus.out_data  <= sv_p1;
            bus.out_addr  <= cur;
            bus.out_valid <= 1'b1;
            timed_out     <= 1'b1;
            state         <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (cur == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              cur        <= cur + 1'b1;
              settle_cnt <= '0;
              state      <= S_SETTLE;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secmem_reader.sv
// Directed bench for secmem_reader: scenario table of full sweeps plus hand-written
// reset-mid-sweep sequence, driven against a small behavioural secure-memory model.
module tb_secmem_reader;
  localparam int AB = 5;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic timed_out;

  secmem_reader_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  secmem_reader #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .LAST_ADDR(31),
    .SETTLE_CYCLES(16), .STABLE_COUNT(4), .TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .done(done), .timed_out(timed_out), .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory model: 0 static, 1 glitch for 20 cycles after address change, 2 toggle forever at addr 5
  int          mode = 0;
  logic [31:0] since_chg = '0;
  logic [AB-1:0] last_addr_seen = '0;

  always @(posedge clk) begin
    if (start || bus.mem_addr != last_addr_seen) since_chg <= '0;
    else since_chg <= since_chg + 1;
    last_addr_seen <= bus.mem_addr;
  end

  always_comb begin
    logic [DB-1:0] fin;
    fin = {{(DB-AB){1'b0}}, bus.mem_addr} ^ 8'hA5;
    bus.mem_value = fin;
    if (mode == 1 && since_chg < 20 && since_chg[1]) bus.mem_value = ~fin;
    if (mode == 2 && bus.mem_addr == 5 && since_chg[0]) bus.mem_value = ~fin;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int   mode;
    int   stall_byte;
    int   bad_addr;
    logic exp_to;
    logic poke;
  } vec_t;

  vec_t tbl[5];

  task automatic run_sweep(input vec_t v);
    int nbytes, ndone, extra_done, stall_cnt, t_addr, t_emit;
    logic finished, prev_v, prev_hs, hs;
    logic [DB-1:0] held_d, exp_d;
    logic [AB-1:0] held_a;
    nbytes = 0; ndone = 0; extra_done = 0; stall_cnt = 0;
    t_addr = -1; t_emit = -1; finished = 1'b0; prev_v = 1'b0; prev_hs = 1'b0;
    held_d = '0; held_a = '0;
    mode = v.mode;
    bus.out_ready = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("start_busy", busy, 1);
    check("start_tmo_clear", timed_out, 0);
    check("start_addr", bus.mem_addr, 0);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (prev_v && !prev_hs) check("valid_held", bus.out_valid, 1);
      start = v.poke && (cyc == 100);
      bus.out_ready = 1'b1;
      if (bus.out_valid && int'(bus.out_addr) == v.stall_byte && stall_cnt < 50) begin
        bus.out_ready = 1'b0;
        if (stall_cnt == 0) begin
          held_d = bus.out_data;
          held_a = bus.out_addr;
        end else if (stall_cnt == 49) begin
          check("stall_data", bus.out_data, held_d);
          check("stall_addr", bus.out_addr, held_a);
          check("stall_mem_addr", bus.mem_addr, v.stall_byte);
        end
        stall_cnt++;
      end
      if (v.bad_addr >= 0 && t_addr < 0 && int'(bus.mem_addr) == v.bad_addr) t_addr = cyc;
      hs = bus.out_valid && bus.out_ready;
      if (hs) begin
        check("byte_addr", bus.out_addr, nbytes);
        exp_d = {{(DB-AB){1'b0}}, bus.out_addr} ^ 8'hA5;
        if (int'(bus.out_addr) == v.bad_addr) begin
          t_emit = cyc;
          check("tmo_data", (bus.out_data == exp_d) || (bus.out_data == ~exp_d), 1);
          check("tmo_flag", timed_out, 1);
        end else begin
          check("byte_data", bus.out_data, exp_d);
        end
        nbytes++;
      end
      if (done) begin
        ndone++;
        check("done_busy", busy, 0);
        check("done_tmo", timed_out, v.exp_to);
        if (v.poke) start = 1'b1;
        finished = 1'b1;
        break;
      end
      prev_v = bus.out_valid;
      prev_hs = hs;
      @(negedge clk);
    end
    if (!finished) check("sweep_budget", 0, 1);
    @(negedge clk) start = 1'b0;
    check("done_one_cycle", done, 0);
    repeat (5) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("idle_after_done", busy, 0);
    check("tmo_sticky", timed_out, v.exp_to);
    check("byte_count", nbytes, 32);
    check("done_count", ndone + extra_done, 1);
    if (v.bad_addr >= 0) check("tmo_latency", (t_emit - t_addr >= 110) && (t_emit - t_addr <= 125), 1);
    if (v.stall_byte >= 0) check("stall_len", stall_cnt, 50);
  endtask

  initial begin
    tbl[0] = '{mode: 0, stall_byte: -1, bad_addr: -1, exp_to: 1'b0, poke: 1'b0};
    tbl[1] = '{mode: 0, stall_byte:  3, bad_addr: -1, exp_to: 1'b0, poke: 1'b0};
    tbl[2] = '{mode: 1, stall_byte: -1, bad_addr: -1, exp_to: 1'b0, poke: 1'b0};
    tbl[3] = '{mode: 2, stall_byte: -1, bad_addr:  5, exp_to: 1'b1, poke: 1'b0};
    tbl[4] = '{mode: 0, stall_byte: -1, bad_addr: -1, exp_to: 1'b0, poke: 1'b1};

    reset = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tmo", timed_out, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_addr", bus.out_addr, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_sweep(tbl[i]);

    // Reset while byte 10 is waiting in EMIT
    begin
      logic found;
      found = 1'b0;
      mode = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
        if (bus.out_valid && bus.out_addr == 10) begin
          found = 1'b1;
          break;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
      end
      bus.out_ready = 1'b0;
      check("mid_reached_byte10", found, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_tmo", timed_out, 0);
      check("mid_rst_mem_addr", bus.mem_addr, 0);
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_data", bus.out_data, 0);
      check("mid_rst_addr", bus.out_addr, 0);
      @(negedge clk) reset = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_idle", busy, 0);
      check("mid_rst_no_valid", bus.out_valid, 0);
    end

    run_sweep(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
